// File: rtl/mxint8_unpack_stream_pkg.sv
// Shared constants for the MXINT8 block unpacker: block geometry, float32 field
// widths and the special encodings used by the element converter.
package mxint8_unpack_stream_pkg;

  localparam int DEFAULT_BLOCK_SIZE   = 32;
  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int FLOAT32_WIDTH        = 32;
  localparam int FLOAT32_EXP_WIDTH    = 8;
  localparam int FLOAT32_MANT_WIDTH   = 23;

  localparam logic [FLOAT32_WIDTH-1:0]      FLOAT32_QNAN     = 32'h7FC00000;
  localparam logic [FLOAT32_EXP_WIDTH-1:0]  FLOAT32_MAX_EXP  = 8'hFE;
  localparam logic [FLOAT32_MANT_WIDTH-1:0] FLOAT32_MANT_MAX = 23'h7FFFFF;
  localparam logic [SCALE_WIDTH-1:0]        SCALE_NAN        = 8'hFF;

  function automatic logic [FLOAT32_WIDTH-1:0] float32_pack(
    input logic                          sign,
    input logic [FLOAT32_EXP_WIDTH-1:0]  exp_f,
    input logic [FLOAT32_MANT_WIDTH-1:0] mant
  );
    return {sign, exp_f, mant};
  endfunction

endpackage

// File: rtl/mxint8_unpack_stream_if.sv
// Block-in / beat-out handshake bundle for mxint8_unpack_stream.
// slave = the unpacker, master = the producer/consumer side around it.
interface mxint8_unpack_stream_if #(
  parameter int BLOCK_SIZE  = mxint8_unpack_stream_pkg::DEFAULT_BLOCK_SIZE,
  parameter int INDEX_WIDTH = $clog2(BLOCK_SIZE)
);
  import mxint8_unpack_stream_pkg::*;

  logic                                       i_valid;
  logic                                       o_ready;
  logic [SCALE_WIDTH-1:0]                     i_scale;
  logic [MXINT8_ELEMENT_WIDTH*BLOCK_SIZE-1:0] i_mxint8_elements;
  logic                                       o_valid;
  logic                                       i_ready;
  logic [FLOAT32_WIDTH-1:0]                   o_float32;
  logic [INDEX_WIDTH-1:0]                     o_index;
  logic                                       o_last;

  modport slave (
    input  i_valid, i_scale, i_mxint8_elements, i_ready,
    output o_ready, o_valid, o_float32, o_index, o_last
  );

  modport master (
    output i_valid, i_scale, i_mxint8_elements, i_ready,
    input  o_ready, o_valid, o_float32, o_index, o_last
  );

endinterface

// File: rtl/mxint8_element_to_float32.sv
// Combinational conversion of one MXINT8 element (Q1.6 two's complement) under
// a biased shared scale into an exact float32; only scale overflow clamps.
module mxint8_element_to_float32
  import mxint8_unpack_stream_pkg::*;
(
  input  logic [SCALE_WIDTH-1:0]          i_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_element,
  output logic [FLOAT32_WIDTH-1:0]        o_float32
);

  logic               sign;
  logic [8:0]         mag;
  logic [2:0]         lead;
  logic signed [9:0]  exp_s;
  logic [23:0]        sig_full;
  logic [9:0]         rsh;

  always_comb begin
    sign = i_element[7];
    // 9-bit magnitude so that -128 maps to 128 instead of wrapping
    mag  = sign ? (9'd0 - {1'b1, i_element}) : {1'b0, i_element};
    lead = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) lead = 3'(b);
    end
    exp_s    = $signed({2'b00, i_scale}) + $signed({7'd0, lead}) - 10'sd6;
    sig_full = {15'd0, mag} << (5'd23 - {2'd0, lead});
    rsh      = 10'd1 - $unsigned(exp_s);

    if (i_scale == SCALE_NAN) begin
      o_float32 = FLOAT32_QNAN;
    end else if (i_element == '0) begin
      o_float32 = '0;
    end else if (exp_s >= 10'sd255) begin
      o_float32 = float32_pack(sign, FLOAT32_MAX_EXP, FLOAT32_MANT_MAX);
    end else if (exp_s <= 10'sd0) begin
      // E >= -6 here, so the right shift never drops a set bit
      o_float32 = float32_pack(sign, 8'd0, 23'(sig_full >> rsh));
    end else begin
      o_float32 = float32_pack(sign, exp_s[7:0], sig_full[22:0]);
    end
  end

endmodule

// File: rtl/mxint8_unpack_stream.sv
// Accepts one MXINT8 block and streams BLOCK_SIZE float32 beats, element 0 first.
// MXINT8_UNPACK_PINGPONG_EN adds a pending buffer for zero-bubble back-to-back blocks.
//
// state      | meaning
// ST_IDLE    | no active block; ready for a new one
// ST_STREAM  | active block buffered; emitting beat index_q
module mxint8_unpack_stream
  import mxint8_unpack_stream_pkg::*;
#(
  parameter int BLOCK_SIZE  = DEFAULT_BLOCK_SIZE,
  parameter int INDEX_WIDTH = $clog2(BLOCK_SIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mxint8_unpack_stream_if.slave bus
);

  localparam int ELEMS_W = MXINT8_ELEMENT_WIDTH * BLOCK_SIZE;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(BLOCK_SIZE - 1);

  logic [0:0]                      state_q, state_d;
  logic                            rdy_en_q, rdy_en_d;
  logic [INDEX_WIDTH-1:0]          index_q, index_d;
  logic [SCALE_WIDTH-1:0]          scale_q, scale_d;
  logic [ELEMS_W-1:0]              elems_q, elems_d;
  logic                            stream_on, beat_last, xfer, accept;
  logic [MXINT8_ELEMENT_WIDTH-1:0] elem_sel;
  logic [FLOAT32_WIDTH-1:0]        conv;

`ifdef MXINT8_UNPACK_PINGPONG_EN
  logic                   pend_valid_q, pend_valid_d;
  logic [SCALE_WIDTH-1:0] pend_scale_q, pend_scale_d;
  logic [ELEMS_W-1:0]     pend_elems_q, pend_elems_d;

  assign bus.o_ready = rdy_en_q && (!stream_on || !pend_valid_q);
`else
  assign bus.o_ready = rdy_en_q && !stream_on;
`endif

  always_comb begin
    stream_on = (state_q == ST_STREAM);
    beat_last = stream_on && (index_q == LAST_INDEX);
    xfer      = stream_on && bus.i_ready;
    accept    = bus.i_valid && bus.o_ready;
  end

  always_comb begin
    state_d  = state_q;
    rdy_en_d = 1'b1;
    index_d  = index_q;
    scale_d  = scale_q;
    elems_d  = elems_q;
`ifdef MXINT8_UNPACK_PINGPONG_EN
    pend_valid_d = pend_valid_q;
    pend_scale_d = pend_scale_q;
    pend_elems_d = pend_elems_q;
`endif
    if (!stream_on) begin
      if (accept) begin
        state_d = ST_STREAM;
        index_d = '0;
        scale_d = bus.i_scale;
        elems_d = bus.i_mxint8_elements;
      end
    end else if (xfer && beat_last) begin
      index_d = '0;
`ifdef MXINT8_UNPACK_PINGPONG_EN
      // accept is only possible here when nothing is pending
      if (pend_valid_q) begin
        scale_d      = pend_scale_q;
        elems_d      = pend_elems_q;
        pend_valid_d = 1'b0;
      end else if (accept) begin
        scale_d = bus.i_scale;
        elems_d = bus.i_mxint8_elements;
      end else begin
        state_d = ST_IDLE;
      end
`else
      state_d = ST_IDLE;
`endif
    end else begin
      if (xfer) index_d = index_q + 1'b1;
`ifdef MXINT8_UNPACK_PINGPONG_EN
      if (accept) begin
        pend_valid_d = 1'b1;
        pend_scale_d = bus.i_scale;
        pend_elems_d = bus.i_mxint8_elements;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      index_q  <= '0;
      scale_q  <= '0;
      elems_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
      index_q  <= index_d;
      scale_q  <= scale_d;
      elems_q  <= elems_d;
    end
  end

`ifdef MXINT8_UNPACK_PINGPONG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_valid_q <= 1'b0;
      pend_scale_q <= '0;
      pend_elems_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_scale_q <= pend_scale_d;
      pend_elems_q <= pend_elems_d;
    end
  end
`endif

  assign elem_sel = elems_q[{index_q, 3'b000} +: MXINT8_ELEMENT_WIDTH];

  mxint8_element_to_float32 u_conv (
    .i_scale   (scale_q),
    .i_element (elem_sel),
    .o_float32 (conv)
  );

  assign bus.o_valid   = stream_on;
  assign bus.o_index   = index_q;
  assign bus.o_last    = beat_last;
  assign bus.o_float32 = stream_on ? conv : '0;

endmodule
